// File: rtl/wb_pkg.sv
// Shared helpers for the white-balance blocks: AXI4-Stream width math,
// gain width and unity constant, and the gain rounding-mode encoding.
package wb_pkg;

  typedef enum logic [0:0] {
    GAIN_MODE_TRUNC = 1'b0,
    GAIN_MODE_ROUND = 1'b1
  } gain_mode_e;

  function automatic int tdata_width(input int px, input int ch);
    return ((px * ch + 7) / 8) * 8;
  endfunction

  function automatic int coef_width(input int int_w, input int fract_w);
    return int_w + fract_w;
  endfunction

  function automatic logic [31:0] fixed_one(input int fract_w);
    return 32'd1 << fract_w;
  endfunction

endpackage

// File: rtl/wb_gain_lane.sv
// One colour channel: S1 registers px*gain, S2 registers the saturated result.
// Define WB_GAIN_ROUND_EN to round half-up before the shift instead of truncating.
module wb_gain_lane
  import wb_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int INT_WIDTH   = 4,
  parameter int FRACT_WIDTH = 10
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_s1_en,
  input  logic                           i_s2_en,
  input  logic [PX_WIDTH-1:0]            i_px,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] i_gain,
  output logic [PX_WIDTH-1:0]            o_px
);

  localparam int PW = PX_WIDTH + INT_WIDTH + FRACT_WIDTH;
  localparam int RW = PX_WIDTH + INT_WIDTH;

`ifdef WB_GAIN_ROUND_EN
  localparam gain_mode_e LANE_MODE = GAIN_MODE_ROUND;
`else
  localparam gain_mode_e LANE_MODE = GAIN_MODE_TRUNC;
`endif

  // Max product plus the half-LSB still fits in PW bits, so no extra carry bit.
  localparam logic [PW-1:0] ROUND_K =
    (LANE_MODE == GAIN_MODE_ROUND) ? (PW'(1) << (FRACT_WIDTH - 1)) : '0;

  logic [PW-1:0]       w_prod;
  logic [PW-1:0]       r_prod;
  logic [RW-1:0]       w_res;
  logic                w_sat;
  logic [PX_WIDTH-1:0] w_px;
  logic [PX_WIDTH-1:0] r_px;
  logic                w_unused_frac;

  assign w_prod = PW'(i_px) * PW'(i_gain) + ROUND_K;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod <= '0;
    end else if (i_s1_en) begin
      r_prod <= w_prod;
    end
  end

  assign w_res         = r_prod[PW-1:FRACT_WIDTH];
  assign w_sat         = |w_res[RW-1:PX_WIDTH];
  assign w_px          = w_sat ? {PX_WIDTH{1'b1}} : w_res[PX_WIDTH-1:0];
  assign w_unused_frac = ^r_prod[FRACT_WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_px <= '0;
    end else if (i_s2_en) begin
      r_px <= w_px;
    end
  end

  assign o_px = r_px;

endmodule

// File: rtl/wb_gain_corrector.sv
// Per-channel white-balance gain on an AXI4-Stream video beat, 2-stage pipeline,
// gains double-buffered and swapped on SOF. Rounding mode via WB_GAIN_ROUND_EN.
module wb_gain_corrector
  import wb_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int CHANNELS    = 3,
  parameter int FRACT_WIDTH = 10,
  parameter int INT_WIDTH   = 4,
  localparam int TDW  = tdata_width(PX_WIDTH, CHANNELS),
  localparam int KW   = TDW / 8,
  localparam int CW   = coef_width(INT_WIDTH, FRACT_WIDTH),
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  // Handshake: a beat transfers on a rising edge where tvalid && tready; the
  // master holds tvalid, tdata and all sideband stable until that transfer.
  input  logic            video_i_tvalid,
  output logic            video_i_tready,
  input  logic [TDW-1:0]  video_i_tdata,
  input  logic [KW-1:0]   video_i_tstrb,
  input  logic [KW-1:0]   video_i_tkeep,
  input  logic            video_i_tlast,
  input  logic            video_i_tuser,
  input  logic            video_i_tid,
  input  logic            video_i_tdest,
  output logic            video_o_tvalid,
  input  logic            video_o_tready,
  output logic [TDW-1:0]  video_o_tdata,
  output logic [KW-1:0]   video_o_tstrb,
  output logic [KW-1:0]   video_o_tkeep,
  output logic            video_o_tlast,
  output logic            video_o_tuser,
  output logic            video_o_tid,
  output logic            video_o_tdest,
  input  logic            coef_wr_i,
  input  logic [SELW-1:0] coef_sel_i,
  input  logic [CW-1:0]   coef_data_i,
  input  logic            commit_i,
  output logic            commit_pending_o
);

  localparam logic [CW-1:0] FIXED_ONE = CW'(fixed_one(FRACT_WIDTH));

  logic                w_s2_adv;
  logic                w_s1_adv;
  logic                w_acc;
  logic                w_s2_load;
  logic                w_apply;
  logic                r_pending;
  logic                r_s1_valid;
  logic                r_s2_valid;
  logic [CW-1:0]       r_shadow      [CHANNELS];
  logic [CW-1:0]       r_active      [CHANNELS];
  logic [CW-1:0]       w_shadow_next [CHANNELS];
  logic [CW-1:0]       w_gain        [CHANNELS];
  logic [PX_WIDTH-1:0] w_lane_px     [CHANNELS];
  logic [TDW-1:0]      w_out_data;

  logic          r_s1_last, r_s1_user, r_s1_id, r_s1_dest;
  logic [KW-1:0] r_s1_strb, r_s1_keep;
  logic          r_s2_last, r_s2_user, r_s2_id, r_s2_dest;
  logic [KW-1:0] r_s2_strb, r_s2_keep;

  // tready depends only on registered state and the downstream tready.
  assign w_s2_adv       = video_o_tready || !r_s2_valid;
  assign w_s1_adv       = w_s2_adv || !r_s1_valid;
  assign video_i_tready = w_s1_adv;
  assign w_acc          = video_i_tvalid && w_s1_adv;
  assign w_s2_load      = w_s2_adv && r_s1_valid;
  assign w_apply        = w_acc && video_i_tuser && (r_pending || commit_i);

  // A same-cycle write lands in the shadow set that an applying SOF copies.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_shadow_next[k] = r_shadow[k];
      if (coef_wr_i && (coef_sel_i == SELW'(k))) begin
        w_shadow_next[k] = coef_data_i;
      end
      w_gain[k] = w_apply ? w_shadow_next[k] : r_active[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_shadow[k] <= FIXED_ONE;
        r_active[k] <= FIXED_ONE;
      end
      r_pending <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_shadow[k] <= w_shadow_next[k];
        if (w_apply) begin
          r_active[k] <= w_shadow_next[k];
        end
      end
      if (w_apply) begin
        r_pending <= 1'b0;
      end else if (commit_i) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign commit_pending_o = r_pending;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_user  <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_dest  <= 1'b0;
      r_s1_strb  <= '0;
      r_s1_keep  <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= video_i_tvalid;
      end
      if (w_acc) begin
        r_s1_last <= video_i_tlast;
        r_s1_user <= video_i_tuser;
        r_s1_id   <= video_i_tid;
        r_s1_dest <= video_i_tdest;
        r_s1_strb <= video_i_tstrb;
        r_s1_keep <= video_i_tkeep;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_user  <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_dest  <= 1'b0;
      r_s2_strb  <= '0;
      r_s2_keep  <= '0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_load) begin
        r_s2_last <= r_s1_last;
        r_s2_user <= r_s1_user;
        r_s2_id   <= r_s1_id;
        r_s2_dest <= r_s1_dest;
        r_s2_strb <= r_s1_strb;
        r_s2_keep <= r_s1_keep;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    wb_gain_lane #(
      .PX_WIDTH   (PX_WIDTH),
      .INT_WIDTH  (INT_WIDTH),
      .FRACT_WIDTH(FRACT_WIDTH)
    ) u_lane (
      .i_clk  (clk_i),
      .i_rst_n(rst_n_i),
      .i_s1_en(w_acc),
      .i_s2_en(w_s2_load),
      .i_px   (video_i_tdata[k*PX_WIDTH +: PX_WIDTH]),
      .i_gain (w_gain[k]),
      .o_px   (w_lane_px[k])
    );
  end

  if (TDW > PX_WIDTH * CHANNELS) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^video_i_tdata[TDW-1:PX_WIDTH*CHANNELS];
  end

  always_comb begin
    w_out_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_out_data[k*PX_WIDTH +: PX_WIDTH] = w_lane_px[k];
    end
  end

  assign video_o_tvalid = r_s2_valid;
  assign video_o_tdata  = w_out_data;
  assign video_o_tlast  = r_s2_last;
  assign video_o_tuser  = r_s2_user;
  assign video_o_tid    = r_s2_id;
  assign video_o_tdest  = r_s2_dest;
  assign video_o_tstrb  = r_s2_strb;
  assign video_o_tkeep  = r_s2_keep;

endmodule

// File: tb/tb_wb_gain_corrector.sv
// Directed bench for wb_gain_corrector: vector table, commit/reset sequences
// and a backpressured frame checked through an expected-beat queue.
module tb_wb_gain_corrector;

  localparam int EW = 44;

`ifdef WB_GAIN_ROUND_EN
  localparam logic [9:0] R3_EX1 = 10'd151;
  localparam logic [9:0] R4_EX1 = 10'd256;
  localparam logic [9:0] R4_EX2 = 10'd16;
`else
  localparam logic [9:0] R3_EX1 = 10'd150;
  localparam logic [9:0] R4_EX1 = 10'd255;
  localparam logic [9:0] R4_EX2 = 10'd15;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        video_i_tvalid = 1'b0;
  logic        video_i_tready;
  logic [31:0] video_i_tdata = '0;
  logic [3:0]  video_i_tstrb = '0;
  logic [3:0]  video_i_tkeep = '0;
  logic        video_i_tlast = 1'b0;
  logic        video_i_tuser = 1'b0;
  logic        video_i_tid = 1'b0;
  logic        video_i_tdest = 1'b0;
  logic        video_o_tvalid;
  logic        video_o_tready = 1'b1;
  logic [31:0] video_o_tdata;
  logic [3:0]  video_o_tstrb;
  logic [3:0]  video_o_tkeep;
  logic        video_o_tlast;
  logic        video_o_tuser;
  logic        video_o_tid;
  logic        video_o_tdest;
  logic        coef_wr_i = 1'b0;
  logic [1:0]  coef_sel_i = '0;
  logic [13:0] coef_data_i = '0;
  logic        commit_i = 1'b0;
  logic        commit_pending_o;

  wb_gain_corrector dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .video_i_tvalid  (video_i_tvalid),
    .video_i_tready  (video_i_tready),
    .video_i_tdata   (video_i_tdata),
    .video_i_tstrb   (video_i_tstrb),
    .video_i_tkeep   (video_i_tkeep),
    .video_i_tlast   (video_i_tlast),
    .video_i_tuser   (video_i_tuser),
    .video_i_tid     (video_i_tid),
    .video_i_tdest   (video_i_tdest),
    .video_o_tvalid  (video_o_tvalid),
    .video_o_tready  (video_o_tready),
    .video_o_tdata   (video_o_tdata),
    .video_o_tstrb   (video_o_tstrb),
    .video_o_tkeep   (video_o_tkeep),
    .video_o_tlast   (video_o_tlast),
    .video_o_tuser   (video_o_tuser),
    .video_o_tid     (video_o_tid),
    .video_o_tdest   (video_o_tdest),
    .coef_wr_i       (coef_wr_i),
    .coef_sel_i      (coef_sel_i),
    .coef_data_i     (coef_data_i),
    .commit_i        (commit_i),
    .commit_pending_o(commit_pending_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int bp_mode = 0;  // 0: always ready, 1: ~40% low, 2: held low

  logic [EW-1:0] exp_q[$];

  always @(posedge clk_i) begin
    #2;
    case (bp_mode)
      1:       video_o_tready = ($urandom_range(0, 99) >= 40);
      2:       video_o_tready = 1'b0;
      default: video_o_tready = 1'b1;
    endcase
  end

  function automatic logic [EW-1:0] pack(input logic [31:0] d, input logic last,
                                         input logic user, input logic id,
                                         input logic dest, input logic [3:0] keep,
                                         input logic [3:0] strb);
    return {strb, keep, dest, id, user, last, d};
  endfunction

  function automatic logic [9:0] exp_chan(input logic [9:0] px, input logic [13:0] g);
    logic [23:0] p;
    logic [13:0] r;
    p = 24'(px) * 24'(g);
`ifdef WB_GAIN_ROUND_EN
    p = p + 24'd512;
`endif
    r = p[23:10];
    return (r > 14'd1023) ? 10'd1023 : r[9:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard / output monitor ----------------
  logic          hold_v = 1'b0;
  logic [EW-1:0] hold_d;

  always @(negedge clk_i) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    act = pack(video_o_tdata, video_o_tlast, video_o_tuser, video_o_tid,
               video_o_tdest, video_o_tkeep, video_o_tstrb);
    if (!rst_n_i) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!video_o_tvalid || act !== hold_d) begin
          failures++;
          $display("FAIL stall_stable actual=%0h/%0b required=%0h/1", act, video_o_tvalid, hold_d);
        end
      end
      hold_v = video_o_tvalid && !video_o_tready;
      hold_d = act;
      if (video_o_tvalid && video_o_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL beat actual=%0h required=%0h", act, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic send_beat(input logic [9:0] p0, input logic [9:0] p1, input logic [9:0] p2,
                           input logic user, input logic last, input logic [3:0] side,
                           input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
    bit done = 0;
    video_i_tvalid = 1'b1;
    video_i_tdata  = {2'b11, p2, p1, p0};
    video_i_tuser  = user;
    video_i_tlast  = last;
    video_i_tid    = side[0];
    video_i_tdest  = side[1];
    video_i_tkeep  = side;
    video_i_tstrb  = ~side;
    for (int c = 0; c < 500 && !done; c++) begin
      if (video_i_tready) begin
        exp_q.push_back(pack({2'b00, e2, e1, e0}, last, user, side[0], side[1], side, ~side));
        done = 1;
      end
      @(negedge clk_i);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL input_accept actual=timeout required=accepted");
    end
    video_i_tvalid = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] sel, input logic [13:0] data, input logic com);
    coef_wr_i   = 1'b1;
    coef_sel_i  = sel;
    coef_data_i = data;
    commit_i    = com;
    @(negedge clk_i);
    coef_wr_i = 1'b0;
    commit_i  = 1'b0;
  endtask

  task automatic do_commit();
    commit_i = 1'b1;
    @(negedge clk_i);
    commit_i = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        commit;
    logic [13:0] g0, g1, g2;
    logic [9:0]  p0, p1, p2;
    logic        user;
    logic [9:0]  e0, e1, e2;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b0, 14'h400, 14'h400, 14'h400, 10'h155, 10'h2AA, 10'h3FF, 1'b1, 10'h155, 10'h2AA, 10'h3FF};
    tbl[1] = '{1'b1, 14'h800, 14'h400, 14'h400, 10'd300, 10'd0, 10'd0, 1'b1, 10'd600, 10'd0, 10'd0};
    tbl[2] = '{1'b0, 14'h000, 14'h000, 14'h000, 10'd600, 10'd1, 10'd1023, 1'b0, 10'd1023, 10'd1, 10'd1023};
    tbl[3] = '{1'b1, 14'h400, 14'h200, 14'h400, 10'd5, 10'd301, 10'd7, 1'b1, 10'd5, R3_EX1, 10'd7};
    tbl[4] = '{1'b1, 14'h600, 14'h100, 14'h3FFF, 10'd200, 10'd1023, 10'd1, 1'b1, 10'd300, R4_EX1, R4_EX2};
    tbl[5] = '{1'b1, 14'h000, 14'h400, 14'h7FF, 10'd1023, 10'd512, 10'd512, 1'b1, 10'd0, 10'd512, 10'd1023};
    tbl[6] = '{1'b1, 14'h3FFF, 14'h401, 14'h3FF, 10'd1023, 10'd1023, 10'd1023, 1'b1, 10'd1023, 10'd1023, 10'd1022};

    // reset state
    repeat (3) @(negedge clk_i);
    check("rst_tvalid", 64'(video_o_tvalid), 64'd0);
    check("rst_tdata", 64'(video_o_tdata), 64'd0);
    check("rst_side", 64'({video_o_tlast, video_o_tuser, video_o_tid, video_o_tdest,
                           video_o_tkeep, video_o_tstrb}), 64'd0);
    check("rst_pending", 64'(commit_pending_o), 64'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("idle_tready", 64'(video_i_tready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].commit) begin
        write_coef(2'd0, tbl[i].g0, 1'b0);
        write_coef(2'd1, tbl[i].g1, 1'b0);
        write_coef(2'd2, tbl[i].g2, 1'b0);
        do_commit();
        check("pending_set", 64'(commit_pending_o), 64'd1);
      end
      send_beat(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].user, 1'b1, 4'(i),
                tbl[i].e0, tbl[i].e1, tbl[i].e2);
      check("pending_after_beat", 64'(commit_pending_o), 64'd0);
      drain();
    end

    // commit mid-frame: takes effect only at the next SOF
    write_coef(2'd0, 14'h400, 1'b0);
    write_coef(2'd1, 14'h400, 1'b0);
    write_coef(2'd2, 14'h400, 1'b1);
    send_beat(10'd200, 10'd200, 10'd200, 1'b1, 1'b0, 4'hF, 10'd200, 10'd200, 10'd200);
    send_beat(10'd200, 10'd200, 10'd200, 1'b0, 1'b0, 4'hF, 10'd200, 10'd200, 10'd200);
    write_coef(2'd0, 14'h600, 1'b0);
    do_commit();
    check("mid_pending", 64'(commit_pending_o), 64'd1);
    do_commit();
    send_beat(10'd200, 10'd200, 10'd200, 1'b0, 1'b1, 4'hF, 10'd200, 10'd200, 10'd200);
    check("mid_pending_hold", 64'(commit_pending_o), 64'd1);
    send_beat(10'd200, 10'd200, 10'd200, 1'b1, 1'b0, 4'hF, 10'd300, 10'd200, 10'd200);
    check("sof_pending_clear", 64'(commit_pending_o), 64'd0);
    send_beat(10'd200, 10'd200, 10'd200, 1'b0, 1'b1, 4'hF, 10'd300, 10'd200, 10'd200);
    drain();

    // out-of-range write dropped; write and commit in the same cycle
    write_coef(2'd3, 14'h000, 1'b0);
    write_coef(2'd2, 14'h800, 1'b1);
    send_beat(10'd100, 10'd100, 10'd100, 1'b1, 1'b1, 4'h5, 10'd150, 10'd100, 10'd200);
    drain();

    // 64-beat frame under random backpressure, gains {1.5, 1.0, 2.0}
    bp_mode = 1;
    for (int b = 0; b < 64; b++) begin
      logic [9:0] a0, a1, a2;
      a0 = 10'($urandom_range(0, 1023));
      a1 = 10'($urandom_range(0, 1023));
      a2 = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) @(negedge clk_i);
      send_beat(a0, a1, a2, b == 0, b == 63, 4'($urandom_range(0, 15)),
                exp_chan(a0, 14'h600), exp_chan(a1, 14'h400), exp_chan(a2, 14'h800));
    end
    drain();
    bp_mode = 0;
    @(negedge clk_i);

    // reset mid-frame with a pending commit
    write_coef(2'd0, 14'h800, 1'b0);
    do_commit();
    bp_mode = 2;
    @(negedge clk_i);
    @(negedge clk_i);
    send_beat(10'd10, 10'd10, 10'd10, 1'b0, 1'b0, 4'h3, 10'd10, 10'd10, 10'd10);
    send_beat(10'd20, 10'd20, 10'd20, 1'b0, 1'b0, 4'h3, 10'd20, 10'd20, 10'd20);
    check("pre_rst_tvalid", 64'(video_o_tvalid), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_mid_tvalid", 64'(video_o_tvalid), 64'd0);
    check("rst_mid_pending", 64'(commit_pending_o), 64'd0);
    exp_q.delete();
    bp_mode = 0;
    @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    send_beat(10'd100, 10'd100, 10'd100, 1'b1, 1'b1, 4'h9, 10'd100, 10'd100, 10'd100);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
